mouse_bounds_sequencer: RTL
===========================

// Module: mouse_bounds_sequencer
// PURPOSE
//  Sequences MouseCtl's limit-programming strobes (setmin_x/setmax_x/setmin_y/setmax_y + value) on menu<->game
//  mode changes. Debounces the game/menu buttons and holds each strobe long enough for MouseCtl (130 MHz) to sample.
//  Queues one pending mode request. Sits in pclk domain between board buttons and MouseCtl config inputs.
// PARAMETERS
//  GAME_MIN_X       361    game-area left limit
//  GAME_MAX_X       661    game-area right limit
//  GAME_MIN_Y       367    game-area top limit
//  GAME_MAX_Y       667    game-area bottom limit
//  MENU_MIN_X/MAX_X 0/1023 menu limits, x
//  MENU_MIN_Y/MAX_Y 0/767  menu limits, y
//  HOLD_CYCLES      4      pclk cycles each strobe is high; same count for the low gap after it (>=1)
//  DEBOUNCE_CYCLES  65000  consecutive stable pclk cycles needed to accept a button level (>=1)
// PORTS
//  pclk      in  1  pixel clock, 65 MHz; sole clock
//  rst       in  1  asynchronous, active-low reset
//  game_btn  in  1  raw async button: request game mode
//  menu_btn  in  1  raw async button: request menu mode
//  setmin_x  out 1  MouseCtl min-x load strobe
//  setmax_x  out 1  MouseCtl max-x load strobe
//  setmin_y  out 1  MouseCtl min-y load strobe
//  setmax_y  out 1  MouseCtl max-y load strobe
//  setx      out 1  MouseCtl x-position load strobe (macro only, else 0)
//  sety      out 1  MouseCtl y-position load strobe (macro only, else 0)
//  value     out 12 data for the active strobe
//  mode      out 1  0=menu, 1=game; mode last fully programmed
//  busy      out 1  sequence in progress
//  cfg_done  out 1  one-cycle pulse when a sequence completes
// BEHAVIOUR
//  - Reset (rst=0): all strobes 0, value=0, mode=0, busy=1, cfg_done=0, pending cleared, debouncers cleared, state=BOOT.
//  - Inputs: 2-FF synchroniser per button, then debounce counter. Level accepted after DEBOUNCE_CYCLES equal samples.
//    Rising edge of accepted level = request. Synchroniser latency: 2 cycles.
//  - Both requests in same cycle: menu wins.
//  - Request while idle and equal to mode: ignored. Request while busy: stored in 1-entry pending; latest wins.
//  - States: BOOT -> LOAD (target=menu; after reset)
//    IDLE -> LOAD on request != mode
//    LOAD (1 cyc): value <= item data, strobes 0
//    STROBE (HOLD_CYCLES): item strobe=1, value stable
//    GAP (HOLD_CYCLES): strobes 0, value stable; -> LOAD next item, or DONE after last item
//    DONE (1 cyc): cfg_done=1, mode<=target
//      -> LOAD if pending valid and pending != target (target<=pending, clear pending)
//      -> else IDLE with busy=0 (stale pending cleared)
//  - Item order: MIN_X, MAX_X, MIN_Y, MAX_Y. Only one strobe high at any cycle. value holds last item when idle.
//  - Timing, N items: busy from the LOAD entry cycle; cfg_done at cycle N*(1+2*HOLD_CYCLES) after LOAD entry.
//    H=4, N=4 -> cycle 36.
//  - busy=1 in BOOT/LOAD/STROBE/GAP/DONE. busy=0 only in IDLE.
//  - mode changes only in DONE; an aborted sequence never occurs (no mid-sequence restart).
//  - Async reset mid-sequence: outputs drop to reset values immediately; full menu boot sequence reruns.
//  - All limits fit 12 bits unsigned. Centre values = (min+max)>>1, computed in 13 bits, truncated to 12.
// CONFIGURATION
//  CENTER_ON_SWITCH_EN defined: two extra items appended after MAX_Y:
//    setx with value=(MIN_X+MAX_X)>>1, then sety with value=(MIN_Y+MAX_Y)>>1.
//    Sequence N=6 (H=4 -> cfg_done at cycle 54). Cursor recentres on every mode change.
//  Not defined: N=4; setx/sety tied 0; cursor position untouched.
// TESTING (DEBOUNCE_CYCLES=4, HOLD_CYCLES=4)
//  1. Release rst -> strobe order min_x/max_x/min_y/max_y, values 0/1023/0/767.
//     Each strobe 4 cycles, 4-cycle gap. cfg_done 1 cycle; mode=0; busy=0.
//  2. Idle menu, game_btn held 10 cycles -> values 361/661/367/667.
//     cfg_done 36 cycles after LOAD entry; mode=1.
//  3. During game sequence, menu_btn pulse then game_btn pulse -> game completes, pending=game==target, IDLE, mode=1.
//     Menu pulse only -> menu sequence starts the cycle after DONE.
//  4. game_btn bounce (toggle every 2 cycles for 20 cycles) then stable -> exactly one sequence.
//     Both buttons pressed the same cycle in menu -> no sequence (menu wins).
//  5. Assert rst during STROBE of MAX_Y -> all strobes 0, value=0, mode=0 immediately.
//     After release, boot menu sequence repeats.
//  6. CENTER_ON_SWITCH_EN, menu->game -> after max_y, setx value=511, sety value=517; cfg_done at cycle 54.
//     Check that at most one strobe is high in every cycle.

Source files
------------

// File: rtl/mouse_bounds_sequencer.sv
// Programs MouseCtl x/y limits (and optionally recentres the cursor) on menu<->game mode changes.
// Optional feature: define CENTER_ON_SWITCH_EN to append setx/sety centre-position items.
module mouse_bounds_sequencer #(
  parameter int GAME_MIN_X      = 361,
  parameter int GAME_MAX_X      = 661,
  parameter int GAME_MIN_Y      = 367,
  parameter int GAME_MAX_Y      = 667,
  parameter int MENU_MIN_X      = 0,
  parameter int MENU_MAX_X      = 1023,
  parameter int MENU_MIN_Y      = 0,
  parameter int MENU_MAX_Y      = 767,
  parameter int HOLD_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_btn,
  input  logic        menu_btn,
  output logic        setmin_x,
  output logic        setmax_x,
  output logic        setmin_y,
  output logic        setmax_y,
  output logic        setx,
  output logic        sety,
  output logic [11:0] value,
  output logic        mode,
  output logic        busy,
  output logic        cfg_done
);

`ifdef CENTER_ON_SWITCH_EN
  localparam int   NITEMS    = 6;
  localparam logic CENTER_EN = 1'b1;
`else
  localparam int   NITEMS    = 4;
  localparam logic CENTER_EN = 1'b0;
`endif

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    ITEM_LAST = 3'(NITEMS - 1);

  localparam logic [12:0] GAME_SUM_X = 13'(GAME_MIN_X) + 13'(GAME_MAX_X);
  localparam logic [12:0] GAME_SUM_Y = 13'(GAME_MIN_Y) + 13'(GAME_MAX_Y);
  localparam logic [12:0] MENU_SUM_X = 13'(MENU_MIN_X) + 13'(MENU_MAX_X);
  localparam logic [12:0] MENU_SUM_Y = 13'(MENU_MIN_Y) + 13'(MENU_MAX_Y);

  typedef enum logic [2:0] {S_BOOT, S_IDLE, S_LOAD, S_STROBE, S_GAP, S_DONE} state_t;

  function automatic logic [11:0] item_value(input logic tgt, input logic [2:0] item);
    case (item)
      3'd0:    item_value = tgt ? 12'(GAME_MIN_X) : 12'(MENU_MIN_X);
      3'd1:    item_value = tgt ? 12'(GAME_MAX_X) : 12'(MENU_MAX_X);
      3'd2:    item_value = tgt ? 12'(GAME_MIN_Y) : 12'(MENU_MIN_Y);
      3'd3:    item_value = tgt ? 12'(GAME_MAX_Y) : 12'(MENU_MAX_Y);
      3'd4:    item_value = tgt ? 12'(GAME_SUM_X >> 1) : 12'(MENU_SUM_X >> 1);
      3'd5:    item_value = tgt ? 12'(GAME_SUM_Y >> 1) : 12'(MENU_SUM_Y >> 1);
      default: item_value = 12'd0;
    endcase
  endfunction

  function automatic logic [5:0] strobe_decode(input logic [2:0] item);
    case (item)
      3'd0:    strobe_decode = 6'b000001;
      3'd1:    strobe_decode = 6'b000010;
      3'd2:    strobe_decode = 6'b000100;
      3'd3:    strobe_decode = 6'b001000;
      3'd4:    strobe_decode = 6'b010000;
      3'd5:    strobe_decode = 6'b100000;
      default: strobe_decode = 6'b000000;
    endcase
  endfunction

  // Index 0 = game button, index 1 = menu button
  logic [1:0]    w_raw;
  logic [1:0]    r_meta, r_sync, r_lvl;
  logic [DW-1:0] r_db_cnt [2];
  logic [1:0]    w_rise;
  logic          w_req_valid, w_req_mode;

  state_t        r_state, w_next;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_item;
  logic          r_target, r_pend_v, r_pend_m, r_mode;
  logic [11:0]   r_value;
  logic          w_pend_v, w_pend_m;
  logic [5:0]    w_strobe;

  assign w_raw = {menu_btn, game_btn};

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_meta      <= 2'b00;
      r_sync      <= 2'b00;
      r_lvl       <= 2'b00;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_lvl[i]    <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // A request fires in the cycle a new high level is accepted; menu overrides game.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = r_sync[i] & ~r_lvl[i] & (r_db_cnt[i] == DB_LAST);
    end
    w_req_valid = |w_rise;
    w_req_mode  = ~w_rise[1];
    w_pend_v    = r_pend_v | w_req_valid;
    w_pend_m    = w_req_valid ? w_req_mode : r_pend_m;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) r_state <= S_BOOT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:   w_next = S_LOAD;
      S_IDLE:   w_next = (w_req_valid && (w_req_mode != r_mode)) ? S_LOAD : S_IDLE;
      S_LOAD:   w_next = S_STROBE;
      S_STROBE: w_next = (r_hold == HOLD_LAST) ? S_GAP : S_STROBE;
      S_GAP: begin
        if (r_hold == HOLD_LAST) w_next = (r_item == ITEM_LAST) ? S_DONE : S_LOAD;
        else                     w_next = S_GAP;
      end
      S_DONE:   w_next = (w_pend_v && (w_pend_m != r_target)) ? S_LOAD : S_IDLE;
      default:  w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_hold   <= '0;
      r_item   <= 3'd0;
      r_target <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend_m <= 1'b0;
      r_mode   <= 1'b0;
      r_value  <= 12'd0;
    end else begin
      // Requests arriving mid-sequence are parked; DONE consumes them itself.
      if ((r_state != S_IDLE) && (r_state != S_DONE) && w_req_valid) begin
        r_pend_v <= 1'b1;
        r_pend_m <= w_req_mode;
      end
      case (r_state)
        S_BOOT: begin
          r_target <= 1'b0;
          r_item   <= 3'd0;
        end
        S_IDLE: begin
          if (w_next == S_LOAD) begin
            r_target <= w_req_mode;
            r_item   <= 3'd0;
          end
        end
        S_LOAD: begin
          r_value <= item_value(r_target, r_item);
          r_hold  <= '0;
        end
        S_STROBE: r_hold <= (r_hold == HOLD_LAST) ? '0 : r_hold + HW'(1);
        S_GAP: begin
          if (r_hold == HOLD_LAST) begin
            r_hold <= '0;
            r_item <= r_item + 3'd1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_DONE: begin
          r_mode   <= r_target;
          r_item   <= 3'd0;
          r_pend_v <= 1'b0;
          if (w_next == S_LOAD) r_target <= w_pend_m;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_strobe = (r_state == S_STROBE) ? strobe_decode(r_item) : 6'b000000;
    setmin_x = w_strobe[0];
    setmax_x = w_strobe[1];
    setmin_y = w_strobe[2];
    setmax_y = w_strobe[3];
    setx     = w_strobe[4] & CENTER_EN;
    sety     = w_strobe[5] & CENTER_EN;
    value    = r_value;
    mode     = r_mode;
    busy     = (r_state != S_IDLE);
    cfg_done = (r_state == S_DONE);
  end

endmodule
